// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code consumer: pops bytes from the receive FIFO, folds E0/F0
// prefixes into single make/break events, tracks Shift / Caps Lock and
// presents each event with its ASCII translation.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for ready; captures the FIFO head and strobes a pop
// POP   | pop strobe low; decodes the captured byte and registers it
module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [7:0]       ascii,
    output logic             shift,
    output logic             caps_lock,
    output logic [CNT_W-1:0] key_count,
    output logic             err
);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] byte_r;
    logic [7:0] held_code;
    logic       held_valid;
    logic       ext_pend;
    logic       brk_pend;

    logic       is_letter;
    logic [4:0] letter_idx;
    logic       is_digit;
    logic [3:0] digit_idx;
    logic [7:0] ascii_nxt;
    logic       is_shift_code;
    logic       is_new_press;

    assign is_shift_code = (byte_r == CODE_LSHIFT) || (byte_r == CODE_RSHIFT);
    assign is_new_press  = !held_valid || (byte_r != held_code);

    // Classify the captured scan code as a letter or digit and find its index
    always_comb begin
        is_letter  = 1'b0;
        letter_idx = 5'd0;
        is_digit   = 1'b0;
        digit_idx  = 4'd0;
        case (byte_r)
            8'h1C: begin is_letter = 1'b1; letter_idx = 5'd0;  end
            8'h32: begin is_letter = 1'b1; letter_idx = 5'd1;  end
            8'h21: begin is_letter = 1'b1; letter_idx = 5'd2;  end
            8'h23: begin is_letter = 1'b1; letter_idx = 5'd3;  end
            8'h24: begin is_letter = 1'b1; letter_idx = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; letter_idx = 5'd5;  end
            8'h34: begin is_letter = 1'b1; letter_idx = 5'd6;  end
            8'h33: begin is_letter = 1'b1; letter_idx = 5'd7;  end
            8'h43: begin is_letter = 1'b1; letter_idx = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; letter_idx = 5'd9;  end
            8'h42: begin is_letter = 1'b1; letter_idx = 5'd10; end
            8'h4B: begin is_letter = 1'b1; letter_idx = 5'd11; end
            8'h3A: begin is_letter = 1'b1; letter_idx = 5'd12; end
            8'h31: begin is_letter = 1'b1; letter_idx = 5'd13; end
            8'h44: begin is_letter = 1'b1; letter_idx = 5'd14; end
            8'h4D: begin is_letter = 1'b1; letter_idx = 5'd15; end
            8'h15: begin is_letter = 1'b1; letter_idx = 5'd16; end
            8'h2D: begin is_letter = 1'b1; letter_idx = 5'd17; end
            8'h1B: begin is_letter = 1'b1; letter_idx = 5'd18; end
            8'h2C: begin is_letter = 1'b1; letter_idx = 5'd19; end
            8'h3C: begin is_letter = 1'b1; letter_idx = 5'd20; end
            8'h2A: begin is_letter = 1'b1; letter_idx = 5'd21; end
            8'h1D: begin is_letter = 1'b1; letter_idx = 5'd22; end
            8'h22: begin is_letter = 1'b1; letter_idx = 5'd23; end
            8'h35: begin is_letter = 1'b1; letter_idx = 5'd24; end
            8'h1A: begin is_letter = 1'b1; letter_idx = 5'd25; end
            8'h45: begin is_digit  = 1'b1; digit_idx  = 4'd0;  end
            8'h16: begin is_digit  = 1'b1; digit_idx  = 4'd1;  end
            8'h1E: begin is_digit  = 1'b1; digit_idx  = 4'd2;  end
            8'h26: begin is_digit  = 1'b1; digit_idx  = 4'd3;  end
            8'h25: begin is_digit  = 1'b1; digit_idx  = 4'd4;  end
            8'h2E: begin is_digit  = 1'b1; digit_idx  = 4'd5;  end
            8'h36: begin is_digit  = 1'b1; digit_idx  = 4'd6;  end
            8'h3D: begin is_digit  = 1'b1; digit_idx  = 4'd7;  end
            8'h3E: begin is_digit  = 1'b1; digit_idx  = 4'd8;  end
            8'h46: begin is_digit  = 1'b1; digit_idx  = 4'd9;  end
            default: ;
        endcase
    end

    // Translate to ASCII using the modifier state from before this byte
    always_comb begin
        ascii_nxt = 8'h00;
        if (!ext_pend) begin
            if (is_letter) begin
                ascii_nxt = ((shift ^ caps_lock) ? 8'h41 : 8'h61) + {3'b000, letter_idx};
            end else if (is_digit) begin
                if (!shift) begin
                    ascii_nxt = 8'h30 + {4'b0000, digit_idx};
                end else begin
                    case (digit_idx)
                        4'd0:    ascii_nxt = 8'h29;
                        4'd1:    ascii_nxt = 8'h21;
                        4'd2:    ascii_nxt = 8'h40;
                        4'd3:    ascii_nxt = 8'h23;
                        4'd4:    ascii_nxt = 8'h24;
                        4'd5:    ascii_nxt = 8'h25;
                        4'd6:    ascii_nxt = 8'h5E;
                        4'd7:    ascii_nxt = 8'h26;
                        4'd8:    ascii_nxt = 8'h2A;
                        default: ascii_nxt = 8'h28;
                    endcase
                end
            end else begin
                case (byte_r)
                    8'h29:   ascii_nxt = 8'h20;
                    8'h5A:   ascii_nxt = 8'h0D;
                    8'h66:   ascii_nxt = 8'h08;
                    default: ascii_nxt = 8'h00;
                endcase
            end
        end
    end

    // Pop/decode FSM with registered event, modifier and press-count outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            byte_r     <= 8'h00;
            nextdata_n <= 1'b1;
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_down   <= 1'b0;
            ascii      <= 8'h00;
            shift      <= 1'b0;
            caps_lock  <= 1'b0;
            key_count  <= '0;
            err        <= 1'b0;
            held_valid <= 1'b0;
            held_code  <= 8'h00;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (overflow) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_r     <= data;
                        nextdata_n <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: begin
                    nextdata_n <= 1'b1;
                    state      <= IDLE;
                    if (byte_r == CODE_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_r == CODE_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        key_valid <= 1'b1;
                        key_code  <= byte_r;
                        key_ext   <= ext_pend;
                        key_down  <= ~brk_pend;
                        ascii     <= ascii_nxt;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        if (!brk_pend) begin
                            // a repeat of the held key pulses key_valid but is not a new press
                            if (is_new_press) begin
                                key_count  <= key_count + {{(CNT_W-1){1'b0}}, 1'b1};
                                held_code  <= byte_r;
                                held_valid <= 1'b1;
                                if (!ext_pend && (byte_r == CODE_CAPS)) begin
                                    caps_lock <= ~caps_lock;
                                end
                            end
                            if (!ext_pend && is_shift_code) begin
                                shift <= 1'b1;
                            end
                        end else begin
                            if (held_valid && (byte_r == held_code)) begin
                                held_valid <= 1'b0;
                            end
                            if (!ext_pend && is_shift_code) begin
                                shift <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a queue-based FIFO feeds scan codes, and a
// keystroke-level reference model predicts every output cycle by cycle.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic [7:0] ascii;
    logic       shift;
    logic       caps_lock;
    logic [7:0] key_count;
    logic       err;

    ps2_key_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .ascii      (ascii),
        .shift      (shift),
        .caps_lock  (caps_lock),
        .key_count  (key_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int kvs   = 0;

    logic [7:0] fifo [$];

    // scan codes of A..Z and 0..9
    logic [7:0] lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool  [14] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h58, 8'h29, 8'h5A, 8'h66,
                               8'h16, 8'h45, 8'h3E, 8'h75, 8'h0E};

    // model: visible outputs (m_), next-cycle outputs (n_), keyboard state
    logic       m_valid, m_ext, m_down, m_shift, m_caps, m_err;
    logic [7:0] m_code, m_ascii, m_count;
    logic       n_valid, n_ext, n_down, n_shift, n_caps, n_err;
    logic [7:0] n_code, n_ascii, n_count;
    logic       held_v, ext_p, brk_p;
    logic [7:0] held_c;
    logic       prev_ready, prev_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic e,
                                            input logic sh, input logic cp);
        string sym;
        sym = ")!@#$%^&*(";
        if (e) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (lcode[i] == c) return ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (dcode[i] == c) return sh ? 8'(sym[i]) : 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        {m_valid, m_ext, m_down, m_shift, m_caps, m_err} = '0;
        {n_valid, n_ext, n_down, n_shift, n_caps, n_err} = '0;
        m_code = 0; m_ascii = 0; m_count = 0;
        n_code = 0; n_ascii = 0; n_count = 0;
        held_v = 0; held_c = 0; ext_p = 0; brk_p = 0;
        prev_ready = 0; prev_pop = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) ext_p = 1;
        else if (b == 8'hF0) brk_p = 1;
        else begin
            n_valid = 1; n_code = b; n_ext = ext_p; n_down = !brk_p;
            n_ascii = ascii_of(b, ext_p, m_shift, m_caps);
            if (!brk_p) begin
                if (!held_v || b != held_c) begin
                    n_count = m_count + 8'd1; held_c = b; held_v = 1;
                    if (!ext_p && b == 8'h58) n_caps = !m_caps;
                end
                if (!ext_p && (b == 8'h12 || b == 8'h59)) n_shift = 1;
            end else begin
                if (held_v && b == held_c) held_v = 0;
                if (!ext_p && (b == 8'h12 || b == 8'h59)) n_shift = 0;
            end
            ext_p = 0; brk_p = 0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        ready = 1'b1;
        data  = fifo[0];
    endtask

    // one clock: check at negedge, advance the model, then let the FIFO pop
    task automatic tick();
        logic exp_pop, pop_obs;
        @(negedge clk);
        m_valid = n_valid; m_code = n_code; m_ext = n_ext; m_down = n_down;
        m_ascii = n_ascii; m_shift = n_shift; m_caps = n_caps; m_count = n_count; m_err = n_err;
        exp_pop = prev_ready && !prev_pop;
        chk("nextdata_n", nextdata_n, !exp_pop);
        chk("key_valid", key_valid, m_valid);
        chk("key_code", key_code, m_code);
        chk("key_ext", key_ext, m_ext);
        chk("key_down", key_down, m_down);
        chk("ascii", ascii, m_ascii);
        chk("shift", shift, m_shift);
        chk("caps_lock", caps_lock, m_caps);
        chk("key_count", key_count, m_count);
        chk("err", err, m_err);
        pop_obs = (nextdata_n === 1'b0);
        if (pop_obs) pops++;
        if (key_valid === 1'b1) kvs++;
        n_valid = 0;
        if (exp_pop && fifo.size() > 0) model_byte(fifo[0]);
        if (overflow) n_err = 1;
        prev_pop = exp_pop;
        prev_ready = ready;
        @(posedge clk);
        #1;
        if (pop_obs && fifo.size() > 0) begin
            void'(fifo.pop_front());
            ready = (fifo.size() > 0);
            data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (fifo.size() > 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_timeout", fifo.size(), 0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        clrn = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0;
        fifo.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key_count", key_count, 0);
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, k0;
        logic [7:0] k;

        // reset then idle with an empty FIFO
        do_reset();
        chk("idle_key_valid", key_valid, 0);
        chk("idle_ascii", ascii, 0);
        chk("idle_err", err, 0);
        p0 = pops;
        repeat (20) tick();
        chk("idle_no_pops", pops - p0, 0);

        // make, break of 'a'
        p0 = pops; k0 = kvs;
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        chk("a_pops", pops - p0, 3);
        chk("a_events", kvs - k0, 2);
        chk("a_count", key_count, 1);
        chk("a_break_down", key_down, 0);
        chk("a_ascii", ascii, 8'h61);

        // shifted 'A'
        do_reset();
        push(8'h12); push(8'h1C);
        drain();
        chk("shA_ascii", ascii, 8'h41);
        chk("shA_shift", shift, 1);
        push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        drain();
        chk("shA_shift_rel", shift, 0);
        chk("shA_count", key_count, 2);

        // caps lock toggling
        do_reset();
        push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
        drain();
        chk("caps_on", caps_lock, 1);
        chk("caps_ascii", ascii, 8'h41);
        push(8'h58);
        drain();
        chk("caps_off", caps_lock, 0);

        // typematic repeat and extended break
        do_reset();
        k0 = kvs;
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain();
        chk("rep_events", kvs - k0, 3);
        chk("rep_count", key_count, 1);
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        chk("ext_flag", key_ext, 1);
        chk("ext_down", key_down, 0);
        chk("ext_ascii", ascii, 0);

        // random keystrokes with irregular FIFO arrival
        do_reset();
        for (int i = 0; i < 120; i++) begin
            k = pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 4) == 0) push(8'hE0);
            if ($urandom_range(0, 1) == 1) push(8'hF0);
            push(k);
            repeat ($urandom_range(0, 5)) tick();
        end
        drain();

        // sticky overflow error
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        tick();
        tick();
        chk("err_set", err, 1);
        repeat (5) tick();
        chk("err_sticky", err, 1);

        // reset asserted while the decoder is in POP
        push(8'h1C);
        tick();
        @(negedge clk);
        chk("midpop_strobe", nextdata_n, 0);
        clrn = 1'b0;
        #1;
        chk("midpop_ndn", nextdata_n, 1);
        chk("midpop_err", err, 0);
        chk("midpop_kv", key_valid, 0);
        @(negedge clk);
        chk("midpop_kv2", key_valid, 0);
        chk("midpop_code", key_code, 0);
        clrn = 1'b1;
        fifo.delete();
        ready = 1'b0; data = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        k0 = kvs;
        repeat (6) tick();
        chk("midpop_no_event", kvs - k0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
